// File: rtl/elev_pkg.sv
// Shared types and defaults for the elevator request scheduler.
// ELEV_WDOG_EN enables the dispatch watchdog in elev_req_sched.
package elev_pkg;

    localparam int DEF_NUM_FLOORS = 3;
    localparam int DEF_FLOOR_W    = 2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_DISPATCH = 2'b01,
        S_HOLD     = 2'b10
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elev_target_pick.sv
// SCAN target selection: nearest pending floor in the sweep direction,
// reversing the sweep only when nothing lies ahead.
module elev_target_pick
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  sweep_dir,
    output logic                  found,
    output logic [FLOOR_W-1:0]    target,
    output logic                  new_dir
);

    logic               found_up;
    logic               found_dn;
    logic [FLOOR_W-1:0] tgt_up;
    logic [FLOOR_W-1:0] tgt_dn;

    always_comb begin
        found_up = 1'b0;
        found_dn = 1'b0;
        tgt_up   = '0;
        tgt_dn   = '0;
        found    = 1'b0;
        target   = '0;
        new_dir  = sweep_dir;

        // Descending scan leaves the lowest floor above; ascending scan the highest below.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(current_floor))) begin
                found_up = 1'b1;
                tgt_up   = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(current_floor))) begin
                found_dn = 1'b1;
                tgt_dn   = FLOOR_W'(i);
            end
        end

        if (sweep_dir == DIR_UP) begin
            if (found_up) begin
                found   = 1'b1;
                target  = tgt_up;
                new_dir = DIR_UP;
            end else if (found_dn) begin
                found   = 1'b1;
                target  = tgt_dn;
                new_dir = DIR_DOWN;
            end
        end else begin
            if (found_dn) begin
                found   = 1'b1;
                target  = tgt_dn;
                new_dir = DIR_DOWN;
            end else if (found_up) begin
                found   = 1'b1;
                target  = tgt_up;
                new_dir = DIR_UP;
            end
        end
    end

endmodule

// File: rtl/elev_req_sched.sv
// Request scheduler in front of the elevator FSM: latches calls, dispatches one
// SCAN target at a time, retires on arrival. Define ELEV_WDOG_EN for the dispatch watchdog.
module elev_req_sched
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
    parameter int FLOOR_W       = DEF_FLOOR_W,
    parameter int DOOR_HOLD_CYC = 4
`ifdef ELEV_WDOG_EN
    ,
    parameter int WDOG_CYC      = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] btn_req,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    output logic [NUM_FLOORS-1:0] floor_req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  sweep_dir,
    output logic                  busy,
    output logic                  at_floor_ack,
    output logic                  fault
);

    localparam int HOLD_W = $clog2(DOOR_HOLD_CYC + 1);

    state_t                state_q, state_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic [NUM_FLOORS-1:0] floor_req_q, floor_req_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  sweep_dir_q, sweep_dir_d;
    logic                  at_floor_ack_q, at_floor_ack_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;

    logic [NUM_FLOORS-1:0] cf_hit;
    logic [NUM_FLOORS-1:0] retire;
    logic                  pick_found;
    logic [FLOOR_W-1:0]    pick_target;
    logic                  pick_dir;

`ifdef ELEV_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic                  fault_q, fault_d;
`endif

    function automatic logic [NUM_FLOORS-1:0] to_onehot(input logic [FLOOR_W-1:0] f);
        return NUM_FLOORS'(1) << f;
    endfunction

    elev_target_pick #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_pick (
        .pending       (pending_q),
        .current_floor (current_floor),
        .sweep_dir     (sweep_dir_q),
        .found         (pick_found),
        .target        (pick_target),
        .new_dir       (pick_dir)
    );

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        floor_req_d    = floor_req_q;
        sweep_dir_d    = sweep_dir_q;
        hold_cnt_d     = hold_cnt_q;
        at_floor_ack_d = 1'b0;
`ifdef ELEV_WDOG_EN
        wdog_d         = wdog_q;
        fault_d        = fault_q;
`endif

        // Out-of-range floor codes match no bit, so they never retire anything.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cf_hit[i] = (int'(current_floor) == i);
        end
        retire = door_open ? cf_hit : '0;

        case (state_q)
            S_IDLE: begin
                // The car never opens its door from idle, so at-floor calls are retired here.
                if (|(pending_q & cf_hit)) begin
                    retire         = retire | cf_hit;
                    at_floor_ack_d = 1'b1;
                end else if (pick_found) begin
                    target_d    = pick_target;
                    sweep_dir_d = pick_dir;
                    floor_req_d = to_onehot(pick_target);
                    state_d     = S_DISPATCH;
`ifdef ELEV_WDOG_EN
                    wdog_d      = '0;
`endif
                end
            end
            S_DISPATCH: begin
                if (door_open && (current_floor == target_q)) begin
                    floor_req_d = '0;
                    hold_cnt_d  = HOLD_W'(DOOR_HOLD_CYC);
                    state_d     = S_HOLD;
                end
`ifdef ELEV_WDOG_EN
                else if (wdog_q == WDOG_W'(WDOG_CYC - 1)) begin
                    fault_d     = 1'b1;
                    retire      = retire | to_onehot(target_q);
                    floor_req_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            S_HOLD: begin
                floor_req_d = '0;
                if (hold_cnt_q <= HOLD_W'(1)) begin
                    hold_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: begin
                floor_req_d = '0;
                state_d     = S_IDLE;
            end
        endcase

        pending_d = (pending_q | btn_req) & ~retire;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            target_q       <= '0;
            floor_req_q    <= '0;
            pending_q      <= '0;
            sweep_dir_q    <= DIR_UP;
            at_floor_ack_q <= 1'b0;
            hold_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            floor_req_q    <= floor_req_d;
            pending_q      <= pending_d;
            sweep_dir_q    <= sweep_dir_d;
            at_floor_ack_q <= at_floor_ack_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

`ifdef ELEV_WDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign floor_req    = floor_req_q;
    assign pending      = pending_q;
    assign sweep_dir    = sweep_dir_q;
    assign busy         = (state_q != S_IDLE);
    assign at_floor_ack = at_floor_ack_q;

endmodule

// File: tb/tb_elev_req_sched.sv
// Scoreboard bench for elev_req_sched: each stimulus cycle queues the expected
// registered outputs, which are popped and compared one time unit after the edge.
module tb_elev_req_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] btn_req = 3'b000;
    logic [1:0] current_floor = 2'd0;
    logic       door_open = 1'b0;
    logic [2:0] floor_req;
    logic [2:0] pending;
    logic       sweep_dir;
    logic       busy;
    logic       at_floor_ack;
    logic       fault;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        string      tag;
        logic [2:0] req;
        logic [2:0] pend;
        logic       busy;
        logic       dir;
        logic       ack;
        logic       fault;
    } exp_t;

    exp_t scoreboard[$];

    elev_req_sched dut (
        .clk           (clk),
        .rst           (rst),
        .btn_req       (btn_req),
        .current_floor (current_floor),
        .door_open     (door_open),
        .floor_req     (floor_req),
        .pending       (pending),
        .sweep_dir     (sweep_dir),
        .busy          (busy),
        .at_floor_ack  (at_floor_ack),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic pushExpect(input string tag, input logic [2:0] req, input logic [2:0] pend,
                              input logic eBusy, input logic eDir, input logic eAck);
        exp_t e;
        e.tag   = tag;
        e.req   = req;
        e.pend  = pend;
        e.busy  = eBusy;
        e.dir   = eDir;
        e.ack   = eAck;
        e.fault = 1'b0;
        scoreboard.push_back(e);
    endtask

    task automatic compareFront();
        exp_t e;
        if (scoreboard.size() == 0) begin
            errorCount++;
            $display("[TB] FAIL sb_empty: got no entry, expected one");
        end else begin
            e = scoreboard.pop_front();
            checkOutput({e.tag, ".floor_req"}, 8'(floor_req),    8'(e.req));
            checkOutput({e.tag, ".pending"},   8'(pending),      8'(e.pend));
            checkOutput({e.tag, ".busy"},      8'(busy),         8'(e.busy));
            checkOutput({e.tag, ".sweep_dir"}, 8'(sweep_dir),    8'(e.dir));
            checkOutput({e.tag, ".ack"},       8'(at_floor_ack), 8'(e.ack));
            checkOutput({e.tag, ".fault"},     8'(fault),        8'(e.fault));
        end
    endtask

    // Drive one cycle of inputs, queue the post-edge expectation, then compare it.
    task automatic applyStimulus(input string tag, input logic [2:0] btn, input logic [1:0] cf,
                                 input logic door, input logic [2:0] eReq, input logic [2:0] ePend,
                                 input logic eBusy, input logic eDir, input logic eAck);
        btn_req       = btn;
        current_floor = cf;
        door_open     = door;
        pushExpect(tag, eReq, ePend, eBusy, eDir, eAck);
        @(posedge clk);
        #1;
        compareFront();
    endtask

    initial begin
        #12;
        pushExpect("reset", 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        compareFront();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Press-to-request latency, arrival, then four busy hold cycles.
        applyStimulus("lat_set",  3'b100, 2'd0, 1'b0, 3'b000, 3'b100, 1'b0, 1'b1, 1'b0);
        applyStimulus("lat_req",  3'b000, 2'd0, 1'b0, 3'b100, 3'b100, 1'b1, 1'b1, 1'b0);
        applyStimulus("lat_arr",  3'b000, 2'd2, 1'b1, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus("lat_hold", 3'b000, 2'd2, 1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        applyStimulus("lat_done", 3'b000, 2'd2, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);

        // SCAN up from floor 1 first, then reverse down to floor 0.
        applyStimulus("scan_set",  3'b101, 2'd1, 1'b0, 3'b000, 3'b101, 1'b0, 1'b1, 1'b0);
        applyStimulus("scan_up",   3'b000, 2'd1, 1'b0, 3'b100, 3'b101, 1'b1, 1'b1, 1'b0);
        applyStimulus("scan_arr2", 3'b000, 2'd2, 1'b1, 3'b000, 3'b001, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus("scan_hold", 3'b000, 2'd2, 1'b0, 3'b000, 3'b001, 1'b1, 1'b1, 1'b0);
        applyStimulus("scan_idle", 3'b000, 2'd2, 1'b0, 3'b000, 3'b001, 1'b0, 1'b1, 1'b0);
        applyStimulus("scan_rev",  3'b000, 2'd2, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0);
        applyStimulus("scan_arr0", 3'b000, 2'd0, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus("scan_hold0", 3'b000, 2'd0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        applyStimulus("scan_done", 3'b000, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        // Call at the floor the idle car already occupies.
        applyStimulus("ack_set",   3'b010, 2'd1, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0);
        applyStimulus("ack_pulse", 3'b000, 2'd1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        applyStimulus("ack_end",   3'b000, 2'd1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        // Press on the arrival floor in the arrival cycle: the clear wins.
        applyStimulus("cb_set",   3'b100, 2'd1, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0);
        applyStimulus("cb_go",    3'b000, 2'd1, 1'b0, 3'b100, 3'b100, 1'b1, 1'b1, 1'b0);
        applyStimulus("cb_clash", 3'b101, 2'd2, 1'b1, 3'b000, 3'b001, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus("cb_hold", 3'b000, 2'd2, 1'b0, 3'b000, 3'b001, 1'b1, 1'b1, 1'b0);
        applyStimulus("cb_idle",  3'b000, 2'd2, 1'b0, 3'b000, 3'b001, 1'b0, 1'b1, 1'b0);
        applyStimulus("cb_next",  3'b000, 2'd2, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0);
        applyStimulus("cb_arr0",  3'b000, 2'd0, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus("cb_hold0", 3'b000, 2'd0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        applyStimulus("cb_done",  3'b000, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

        // Out-of-range floor code while sweeping down: target 2, then async reset mid-dispatch.
        applyStimulus("oor_set",  3'b101, 2'd3, 1'b0, 3'b000, 3'b101, 1'b0, 1'b0, 1'b0);
        applyStimulus("oor_go",   3'b000, 2'd3, 1'b0, 3'b100, 3'b101, 1'b1, 1'b0, 1'b0);
        applyStimulus("oor_wait", 3'b000, 2'd3, 1'b0, 3'b100, 3'b101, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        pushExpect("async_rst", 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        #1;
        compareFront();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("post_rst", 3'b000, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
